systolic_tile_scheduler: RTL and testbench

//  Sequences an MxM by MxM matrix multiply (M up to MAX_DIM) onto the NxN systolic array as tiles.

---
 rtl/systolic_tile_scheduler.sv | 142 ++++++++++++++
 tb/tb_systolic_tile_scheduler.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/systolic_tile_scheduler.sv
// systolic_tile_scheduler: walks i/j/k tiles of an MxM matmul; start_i/dim_i/base_*_i in, tile addresses/sizes/accum with new_data_o pulse out, tile_done_i back, busy_o/done_o/err_o status
module systolic_tile_scheduler #(
  parameter int N = 4,
  parameter int ADDR_W = 12,
  parameter int MAX_DIM = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [5:0]        dim_i,
  input  logic [ADDR_W-1:0] base_a_i,
  input  logic [ADDR_W-1:0] base_b_i,
  input  logic [ADDR_W-1:0] base_c_i,
  input  logic              tile_done_i,
  output logic              new_data_o,
  output logic [ADDR_W-1:0] addr_a_o,
  output logic [ADDR_W-1:0] addr_b_o,
  output logic [ADDR_W-1:0] addr_c_o,
  output logic [5:0]        row_stride_o,
  output logic [3:0]        tile_m_o,
  output logic [3:0]        tile_n_o,
  output logic [3:0]        tile_k_o,
  output logic              accum_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);
  localparam int LG = $clog2(N);
  localparam logic [7:0] N8 = 8'(N);
  typedef enum logic [2:0] {IDLE, SETUP, ISSUE, WAIT, ADVANCE, FINISH} state_t;
  state_t state_q;
  logic [5:0] m_q;
  logic [4:0] t_q, i_q, j_q, k_q;
  logic [ADDR_W-1:0] base_a_q, base_b_q, base_c_q, nm_q, io_q, jo_q, ko_q, kr_q;
  logic new_data_q, busy_q, done_q, err_q;
  logic [7:0] rem_m, rem_n, rem_k;
  logic legal, k_last, j_last, i_last;
  always_comb begin
    legal = m_q != 6'd0 && {1'b0, m_q} <= 7'(MAX_DIM);
    k_last = k_q == t_q - 5'd1;
    j_last = j_q == t_q - 5'd1;
    i_last = i_q == t_q - 5'd1;
    rem_m = {2'b0, m_q} - ({3'b0, i_q} << LG);
    rem_n = {2'b0, m_q} - ({3'b0, j_q} << LG);
    rem_k = {2'b0, m_q} - ({3'b0, k_q} << LG);
  end
  assign tile_m_o = rem_m > N8 ? 4'(N) : rem_m[3:0];
  assign tile_n_o = rem_n > N8 ? 4'(N) : rem_n[3:0];
  assign tile_k_o = rem_k > N8 ? 4'(N) : rem_k[3:0];
  assign addr_a_o = base_a_q + io_q + ko_q;
  assign addr_b_o = base_b_q + kr_q + jo_q;
  assign addr_c_o = base_c_q + io_q + jo_q;
  assign row_stride_o = m_q;
  assign accum_o = k_q != 5'd0;
  assign new_data_o = new_data_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign err_o = err_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      m_q <= '0;
      t_q <= '0;
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
      base_a_q <= '0;
      base_b_q <= '0;
      base_c_q <= '0;
      nm_q <= '0;
      io_q <= '0;
      jo_q <= '0;
      ko_q <= '0;
      kr_q <= '0;
      new_data_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      new_data_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start_i) begin
          m_q <= dim_i;
          base_a_q <= base_a_i;
          base_b_q <= base_b_i;
          base_c_q <= base_c_i;
          err_q <= 1'b0;
          busy_q <= 1'b1;
          state_q <= SETUP;
        end
        SETUP: begin
          t_q <= 5'(({1'b0, m_q} + 7'(N - 1)) >> LG);
          nm_q <= ADDR_W'(m_q) << LG;
          i_q <= '0;
          j_q <= '0;
          k_q <= '0;
          io_q <= '0;
          jo_q <= '0;
          ko_q <= '0;
          kr_q <= '0;
          state_q <= legal ? ISSUE : FINISH;
          new_data_q <= legal;
          done_q <= !legal;
          err_q <= !legal;
        end
        ISSUE: state_q <= WAIT;
        WAIT: if (tile_done_i) state_q <= ADVANCE;
        ADVANCE: begin
          state_q <= (k_last && j_last && i_last) ? FINISH : ISSUE;
          new_data_q <= !(k_last && j_last && i_last);
          done_q <= k_last && j_last && i_last;
          // counters freeze on the last tile so outputs keep its values until the next job
          if (!k_last) begin
            k_q <= k_q + 5'd1;
            ko_q <= ko_q + ADDR_W'(N);
            kr_q <= kr_q + nm_q;
          end else if (!j_last) begin
            k_q <= '0;
            ko_q <= '0;
            kr_q <= '0;
            j_q <= j_q + 5'd1;
            jo_q <= jo_q + ADDR_W'(N);
          end else if (!i_last) begin
            k_q <= '0;
            ko_q <= '0;
            kr_q <= '0;
            j_q <= '0;
            jo_q <= '0;
            i_q <= i_q + 5'd1;
            io_q <= io_q + nm_q;
          end
        end
        FINISH: begin
          busy_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_systolic_tile_scheduler.sv
// tb_systolic_tile_scheduler: random tile jobs scored against an arithmetic tile-order model
module tb_systolic_tile_scheduler;
  localparam int N = 4;
  localparam int AW = 12;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_m = 1'b0, start_n = 1'b0, start_i;
  logic td_r = 1'b0, td_m = 1'b0, tile_done_i;
  logic [5:0] dim_i = '0;
  logic [AW-1:0] base_a_i = '0, base_b_i = '0, base_c_i = '0;
  logic new_data_o, accum_o, busy_o, done_o, err_o;
  logic [AW-1:0] addr_a_o, addr_b_o, addr_c_o;
  logic [5:0] row_stride_o;
  logic [3:0] tile_m_o, tile_n_o, tile_k_o;
  assign start_i = start_m | start_n;
  assign tile_done_i = td_r | td_m;
  systolic_tile_scheduler #(.N(N), .ADDR_W(AW), .MAX_DIM(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .dim_i(dim_i),
    .base_a_i(base_a_i), .base_b_i(base_b_i), .base_c_i(base_c_i),
    .tile_done_i(tile_done_i), .new_data_o(new_data_o),
    .addr_a_o(addr_a_o), .addr_b_o(addr_b_o), .addr_c_o(addr_c_o),
    .row_stride_o(row_stride_o), .tile_m_o(tile_m_o), .tile_n_o(tile_n_o),
    .tile_k_o(tile_k_o), .accum_o(accum_o), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [AW-1:0] a, b, c;
    logic [5:0] rs;
    logic [3:0] m, n, k;
    logic acc, err;
  } tile_t;
  tile_t tq[$];
  bit eq[$];
  tile_t got, ex;
  int cyc = 0, n_chk = 0, n_fail = 0, n_done = 0;
  int trig_s = 0, trig_t = 0, resp_cnt = 0, resp_cap = 1 << 30;
  bit last_err = 1'b0, chk_idle = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [58:0] outs();
    return {new_data_o, addr_a_o, addr_b_o, addr_c_o, row_stride_o,
            tile_m_o, tile_n_o, tile_k_o, accum_o, busy_o, done_o, err_o};
  endfunction
  function automatic int mn(int v);
    return v < N ? v : N;
  endfunction
  function automatic int trig();
    return trig_t > trig_s ? trig_t : trig_s;
  endfunction
  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic model(int m, int ba, int bb, int bc);
    int t;
    tile_t e;
    if (m < 1 || m > 32) begin
      eq.push_back(1'b1);
      return;
    end
    t = (m + N - 1) / N;
    for (int i = 0; i < t; i++)
      for (int j = 0; j < t; j++)
        for (int k = 0; k < t; k++) begin
          e.a = AW'((ba + i * N * m + k * N) % 4096);
          e.b = AW'((bb + k * N * m + j * N) % 4096);
          e.c = AW'((bc + i * N * m + j * N) % 4096);
          e.rs = 6'(m);
          e.m = 4'(mn(m - i * N));
          e.n = 4'(mn(m - j * N));
          e.k = 4'(mn(m - k * N));
          e.acc = k != 0;
          e.err = 1'b0;
          tq.push_back(e);
        end
    eq.push_back(1'b0);
  endtask
  task automatic wait_done(int b);
    for (int k = 0; k < 20000 && n_done == b; k++) @(negedge clk);
    check("job completes within bound", 64'(n_done > b), 64'd1);
  endtask
  task automatic run(int m, int ba, int bb, int bc, bit wt);
    int b;
    b = n_done;
    model(m, ba, bb, bc);
    @(negedge clk);
    td_m = 1'b1;
    @(negedge clk);
    td_m = 1'b0;
    start_m = 1'b1;
    dim_i = 6'(m);
    base_a_i = AW'(ba);
    base_b_i = AW'(bb);
    base_c_i = AW'(bc);
    trig_s = cyc;
    @(negedge clk);
    start_m = 1'b0;
    dim_i = 6'($urandom);
    base_a_i = AW'($urandom);
    base_b_i = AW'($urandom);
    base_c_i = AW'($urandom);
    if (wt) wait_done(b);
  endtask
  initial forever begin
    @(negedge clk);
    if (rst) begin
      chk_idle = 1'b0;
      continue;
    end
    if (new_data_o) begin
      got = {addr_a_o, addr_b_o, addr_c_o, row_stride_o, tile_m_o, tile_n_o, tile_k_o, accum_o, err_o};
      if (tq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected tile: got %0h expected none", got);
      end else begin
        ex = tq.pop_front();
        check("tile a/b/c/stride/m/n/k/accum/err", 64'(got), 64'(ex));
      end
      check("new_data latency", 64'(cyc), 64'(trig() + 2));
      check("busy during issue", 64'(busy_o), 64'd1);
    end
    if (done_o) begin
      if (eq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected done: got done=1 expected 0");
      end else begin
        last_err = eq.pop_front();
        check("err at done", 64'(err_o), 64'(last_err));
        check("done latency", 64'(cyc), 64'(trig() + 2));
        check("tiles outstanding at done", 64'(tq.size()), 64'd0);
      end
      check("busy with done", 64'(busy_o), 64'd1);
      n_done++;
      chk_idle = 1'b1;
    end else if (chk_idle) begin
      check("busy/err after done", 64'({busy_o, err_o}), 64'({1'b0, last_err}));
      chk_idle = 1'b0;
    end
  end
  initial forever begin
    @(negedge clk);
    if (new_data_o && !rst) begin
      resp_cnt++;
      if (resp_cnt < resp_cap) begin
        td_r = 1'($urandom_range(0, 1));
        start_n = 1'($urandom_range(0, 1));
        @(negedge clk);
        td_r = 1'b0;
        start_n = 1'b0;
        repeat ($urandom_range(0, 3)) begin
          @(negedge clk);
          start_n = 1'($urandom_range(0, 1));
        end
        td_r = 1'b1;
        start_n = 1'($urandom_range(0, 1));
        trig_t = cyc;
        @(negedge clk);
        td_r = 1'b0;
        start_n = 1'b0;
      end
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    int m, k;
    repeat (3) @(negedge clk);
    check("reset outputs", 64'(outs()), 64'd0);
    rst = 1'b0;
    run(4, 0, 64, 128, 1);
    run(8, 0, 64, 128, 1);
    run(6, 100, 300, 500, 1);
    run(0, 1, 2, 3, 1);
    run(33, 1, 2, 3, 1);
    run(5, 4000, 4090, 4095, 1);
    run(32, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)), 1);
    for (int r = 0; r < 12; r++) begin
      m = $urandom_range(0, 9) == 0 ? int'($urandom_range(33, 63)) : int'($urandom_range(0, 20));
      run(m, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)), 1);
    end
    resp_cap = resp_cnt + 3;
    run(8, 16, 32, 48, 0);
    for (k = 0; k < 300 && resp_cnt < resp_cap; k++) @(negedge clk);
    check("third tile of reset job reached", 64'(resp_cnt), 64'(resp_cap));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid-job reset outputs", 64'(outs()), 64'd0);
    tq.delete();
    eq.delete();
    rst = 1'b0;
    resp_cap = 1 << 30;
    run(8, 0, 64, 128, 1);
    repeat (5) @(negedge clk);
    check("queues drained", 64'(tq.size() + eq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
